// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the logic-BIST controller
package bist_pkg;

  localparam int LFSR_W = 16;

  // x^16+x^14+x^13+x^11+1 in Galois right-shift form
  localparam logic [LFSR_W-1:0] POLY = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    UNLOAD,
    DONE
  } bist_state_e;

endpackage

// File: rtl/bist_lfsr16.sv
// rtl/bist_lfsr16.sv - 16-bit Galois LFSR with parallel load and optional serial input
// Used as PRPG (si_en_i=0) and as SISR signature compactor (si_en_i=1).
module bist_lfsr16
  import bist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  input  logic              step_i,
  input  logic              si_i,
  input  logic              si_en_i,
  output logic [LFSR_W-1:0] q_o
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;
  logic              fb;

  assign fb = q_q[0] ^ (si_en_i & si_i);

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (step_i) begin
      q_d = (q_q >> 1) ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bist_controller.sv
// rtl/bist_controller.sv - logic-BIST controller: PRPG scan-in, shift/capture sequencing, SISR compaction
// Optional macro BIST_SIG_OBS_EN exposes the live SISR value on bist_signature.
module bist_controller
  import bist_pkg::*;
#(
  parameter int                CHAIN_LEN    = 8,
  parameter int                NUM_PATTERNS = 8,
  parameter logic [LFSR_W-1:0] PRPG_SEED    = 16'hACE1,
  parameter logic [LFSR_W-1:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bistmode,
  input  logic              cut_sdo,
  output logic              cut_scanmode,
  output logic              cut_sdi,
  output logic              bistdone,
  output logic              bistpass
`ifdef BIST_SIG_OBS_EN
  ,
  output logic [LFSR_W-1:0] bist_signature
`endif
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_TOTAL = PW'(NUM_PATTERNS);

  bist_state_e       state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]     pat_cnt_q, pat_cnt_d;
  logic              scanmode_q, scanmode_d;
  logic              sdi_q, sdi_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [LFSR_W-1:0] prpg_q;
  logic [LFSR_W-1:0] sisr_q;
  logic              in_idle;
  logic              prpg_step;
  logic              sisr_step;
  logic              unused_prpg;

  assign in_idle   = (state_q == IDLE);
  assign prpg_step = (state_q == SHIFT);
  // The first load leaves no valid response in the chain, so nothing is compacted then.
  assign sisr_step = ((state_q == SHIFT) && (pat_cnt_q != '0)) || (state_q == UNLOAD);
  assign unused_prpg = ^prpg_q[LFSR_W-1:1];

  bist_lfsr16 #(.RESET_VAL(PRPG_SEED)) u_prpg (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (in_idle),
    .load_val_i (PRPG_SEED),
    .step_i     (prpg_step),
    .si_i       (1'b0),
    .si_en_i    (1'b0),
    .q_o        (prpg_q)
  );

  bist_lfsr16 #(.RESET_VAL('0)) u_sisr (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (in_idle),
    .load_val_i ('0),
    .step_i     (sisr_step),
    .si_i       (cut_sdo),
    .si_en_i    (1'b1),
    .q_o        (sisr_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      pat_cnt_q  <= '0;
      scanmode_q <= 1'b0;
      sdi_q      <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      pat_cnt_q  <= pat_cnt_d;
      scanmode_q <= scanmode_d;
      sdi_q      <= sdi_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pat_cnt_d = pat_cnt_q;
    if (!bistmode) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      pat_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          pat_cnt_d = '0;
        end
        SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = CAPTURE;
            bit_cnt_d = '0;
            pat_cnt_d = pat_cnt_q + PW'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        CAPTURE: state_d = (pat_cnt_q < PAT_TOTAL) ? SHIFT : UNLOAD;
        UNLOAD: begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Dropping bistmode forces the idle output values on the same edge as the state change.
  always_comb begin
    scanmode_d = 1'b0;
    sdi_d      = 1'b0;
    done_d     = 1'b0;
    pass_d     = 1'b0;
    if (bistmode) begin
      case (state_q)
        SHIFT: begin
          scanmode_d = 1'b1;
          sdi_d      = prpg_q[0];
        end
        CAPTURE: sdi_d = prpg_q[0];
        UNLOAD:  scanmode_d = 1'b1;
        DONE: begin
          done_d = 1'b1;
          pass_d = (sisr_q == GOLDEN_SIG);
        end
        default: ;
      endcase
    end
  end

  assign cut_scanmode = scanmode_q;
  assign cut_sdi      = sdi_q;
  assign bistdone     = done_q;
  assign bistpass     = pass_q;
`ifdef BIST_SIG_OBS_EN
  assign bist_signature = sisr_q;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// tb/tb_bist_controller.sv - self-checking bench for bist_controller
module tb_bist_controller;

  localparam int C   = 8;
  localparam int NP  = 8;
  localparam int RUN = NP * (C + 1) + C;
  localparam logic [15:0] SEED = 16'hACE1;

  function automatic logic [15:0] lstep(input logic [15:0] q, input logic din);
    return (q >> 1) ^ ((q[0] ^ din) ? 16'hB400 : 16'h0000);
  endfunction

  // Activity during active cycle i: 0 idle, 1 shift, 2 capture, 3 unload, 4 done
  function automatic int phase(input int i);
    if (i < 0) return 0;
    if (i < NP * (C + 1)) return ((i % (C + 1)) < C) ? 1 : 2;
    if (i < RUN) return 3;
    return 4;
  endfunction

  // Signature of a loopback CUT (scan-out = scan-in delayed by one flop)
  function automatic logic [15:0] loop_sig();
    logic [15:0] prpg;
    logic [15:0] sisr;
    logic        out_v;
    logic        sdo_v;
    logic        nout;
    int          ph;
    prpg  = SEED;
    sisr  = 16'h0000;
    out_v = 1'b0;
    sdo_v = 1'b0;
    for (int k = 0; k <= RUN; k++) begin
      ph = phase(k - 1);
      if ((ph == 1 && ((k - 1) / (C + 1)) > 0) || ph == 3) sisr = lstep(sisr, sdo_v);
      nout = (ph == 1 || ph == 2) ? prpg[0] : 1'b0;
      if (ph == 1) prpg = lstep(prpg, 1'b0);
      sdo_v = out_v;
      out_v = nout;
    end
    return sisr;
  endfunction

  localparam logic [15:0] LOOP_SIG = loop_sig();

  logic clk = 1'b0;
  logic reset;
  logic bistmode;
  logic sdo_sel;
  logic sdo_rand;
  logic sdo_ff;
  logic sdo_ff_bad;
  logic dut_sdo;
  logic scan, sdi, done, pass;
  logic bad_scan, bad_sdi, bad_done, bad_pass;
  logic sa0_scan, sa0_sdi, sa0_done, sa0_pass;
`ifdef BIST_SIG_OBS_EN
  logic [15:0] sig_main, sig_bad, sig_sa0;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] first_bits;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    sdo_ff     <= reset ? 1'b0 : sdi;
    sdo_ff_bad <= reset ? 1'b0 : bad_sdi;
  end

  assign dut_sdo = sdo_sel ? sdo_rand : sdo_ff;

  bist_controller #(.CHAIN_LEN(C), .NUM_PATTERNS(NP), .PRPG_SEED(SEED), .GOLDEN_SIG(LOOP_SIG)) dut (
`ifdef BIST_SIG_OBS_EN
    .bist_signature(sig_main),
`endif
    .clk(clk), .reset(reset), .bistmode(bistmode), .cut_sdo(dut_sdo),
    .cut_scanmode(scan), .cut_sdi(sdi), .bistdone(done), .bistpass(pass)
  );

  bist_controller #(.CHAIN_LEN(C), .NUM_PATTERNS(NP), .PRPG_SEED(SEED), .GOLDEN_SIG(LOOP_SIG ^ 16'h0001)) dut_bad (
`ifdef BIST_SIG_OBS_EN
    .bist_signature(sig_bad),
`endif
    .clk(clk), .reset(reset), .bistmode(bistmode), .cut_sdo(sdo_ff_bad),
    .cut_scanmode(bad_scan), .cut_sdi(bad_sdi), .bistdone(bad_done), .bistpass(bad_pass)
  );

  bist_controller #(.CHAIN_LEN(C), .NUM_PATTERNS(NP), .PRPG_SEED(SEED), .GOLDEN_SIG(16'h1234)) dut_sa0 (
`ifdef BIST_SIG_OBS_EN
    .bist_signature(sig_sa0),
`endif
    .clk(clk), .reset(reset), .bistmode(bistmode), .cut_sdo(1'b0),
    .cut_scanmode(sa0_scan), .cut_sdi(sa0_sdi), .bistdone(sa0_done), .bistpass(sa0_pass)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One run from IDLE; abort_k >= 0 drops bistmode (or asserts reset) after active cycle abort_k.
  task automatic run(input int abort_k, input bit use_reset, output int done_k);
    logic [15:0] prpg;
    logic [15:0] sisr;
    logic        sdo_prev, e_scan, e_sdi, e_done, e_pass;
    int          ph;
    int          pidx;
    prpg       = SEED;
    sisr       = 16'h0000;
    done_k     = -1;
    first_bits = 8'h00;
    bistmode   = 1'b1;
    for (int k = 0; k <= RUN + 3; k++) begin
      sdo_prev = sdo_sel ? sdo_rand : sdo_ff;
      @(posedge clk);
      ph   = phase(k - 1);
      pidx = (k - 1) / (C + 1);
      e_scan = (ph == 1 || ph == 3);
      e_sdi  = (ph == 1 || ph == 2) ? prpg[0] : 1'b0;
      e_done = (ph == 4);
      if ((ph == 1 && pidx > 0) || ph == 3) sisr = lstep(sisr, sdo_prev);
      if (ph == 1) prpg = lstep(prpg, 1'b0);
      e_pass = e_done && (sisr == LOOP_SIG);
      @(negedge clk);
      chk("cut_scanmode", 32'(scan), 32'(e_scan));
      chk("cut_sdi", 32'(sdi), 32'(e_sdi));
      chk("bistdone", 32'(done), 32'(e_done));
      chk("bistpass", 32'(pass), 32'(e_pass));
      if (k >= 1 && k <= 8) first_bits[k-1] = sdi;
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (sdo_sel) sdo_rand = 1'($urandom_range(0, 1));
      if (k == abort_k) begin
        if (use_reset) reset = 1'b1;
        else bistmode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(use_reset ? "reset_midrun_outputs" : "abort_outputs", 32'({scan, sdi, done, pass}), 32'h0);
        reset = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    bistmode = 1'b0;
    repeat (n) @(negedge clk);
    chk("idle_outputs", 32'({scan, sdi, done, pass}), 32'h0);
  endtask

  typedef struct {
    logic       rst;
    logic       bm;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[9];
  int   dk;
  int   ab;
  logic [7:0] exp_first;

  initial begin
    reset    = 1'b1;
    bistmode = 1'b0;
    sdo_sel  = 1'b0;
    sdo_rand = 1'b0;
    exp_first = 8'b1110_0001;
    // {scanmode, sdi, done, pass}; outputs lag the state by one edge
    vecs[0] = '{1'b1, 1'b0, 4'b0000};
    vecs[1] = '{1'b1, 1'b0, 4'b0000};
    vecs[2] = '{1'b0, 1'b0, 4'b0000};
    vecs[3] = '{1'b0, 1'b1, 4'b0000};
    vecs[4] = '{1'b1, 1'b1, 4'b0000};
    vecs[5] = '{1'b0, 1'b1, 4'b0000};
    vecs[6] = '{1'b0, 1'b1, 4'b1100};
    vecs[7] = '{1'b0, 1'b0, 4'b0000};
    vecs[8] = '{1'b1, 1'b0, 4'b0000};

    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      reset    = vecs[i].rst;
      bistmode = vecs[i].bm;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'({scan, sdi, done, pass}), 32'(vecs[i].exp));
    end
    reset = 1'b0;
    idle(2);

    run(-1, 1'b0, dk);
    chk("done_edge", 32'(dk), 32'(RUN + 1));
    chk("first_sdi_bits", 32'(first_bits), 32'(exp_first));
    chk("golden_pass", 32'({done, pass}), 32'b11);
    chk("golden_xor1_fail", 32'({bad_done, bad_pass}), 32'b10);
    chk("stuck_at0_fail", 32'({sa0_done, sa0_pass}), 32'b10);
`ifdef BIST_SIG_OBS_EN
    chk("stuck_at0_sig", 32'(sig_sa0), 32'h0);
    chk("loop_sig", 32'(sig_main), 32'(LOOP_SIG));
`endif
    idle(1);
    idle(1);

    run(30, 1'b0, dk);
    idle(2);
    run(-1, 1'b0, dk);
    chk("restart_done_edge", 32'(dk), 32'(RUN + 1));
    chk("restart_first_bits", 32'(first_bits), 32'(exp_first));
    chk("restart_pass", 32'(pass), 32'b1);
    idle(2);

    run(50, 1'b1, dk);
    run(-1, 1'b0, dk);
    chk("post_reset_done_edge", 32'(dk), 32'(RUN + 1));
    chk("post_reset_first_bits", 32'(first_bits), 32'(exp_first));
    idle(2);

    sdo_sel = 1'b1;
    for (int r = 0; r < 4; r++) begin
      sdo_rand = 1'($urandom_range(0, 1));
      ab = (r == 3) ? int'($urandom_range(1, RUN + 2)) : -1;
      run(ab, 1'b0, dk);
      if (ab < 0) chk("rand_done_edge", 32'(dk), 32'(RUN + 1));
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Logic-BIST controller for a single-scan-chain circuit under test (CUT).
- A 16-bit LFSR pseudo-random pattern generator (PRPG) drives the scan-in pin. The controller sequences shift and capture cycles and compacts scan-out data into a 16-bit serial-input signature register (SISR).
- At the end of the run, the final signature is compared with a golden value and the controller reports done and pass.
- The block sits between the test-mode pin (bistmode) and the CUT scan port.

Parameters:
- CHAIN_LEN, 8: CUT scan-chain length; must be at least 1.
- NUM_PATTERNS, 8: number of patterns applied; must be at least 1.
- PRPG_SEED, 16'hACE1: PRPG load value; must be nonzero.
- GOLDEN_SIG, 16'h0000: expected final SISR value; overridden per CUT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bistmode  input  1  level request: 1 runs or holds BIST, 0 returns to idle.
- cut_sdo  input  1  CUT scan-chain serial output.
- cut_scanmode  output  1  1 = CUT shifts, 0 = CUT functional/capture.
- cut_sdi  output  1  CUT scan-chain serial input.
- bistdone  output  1  run complete.
- bistpass  output  1  signature matched GOLDEN_SIG; valid only while bistdone=1.

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, PRPG=PRPG_SEED, SISR=16'h0000, counters=0. All four outputs are 0. Reset wins over every other condition, including a run in progress.
- Polynomial: x^16+x^14+x^13+x^11+1, implemented as a Galois right-shift.
  - PRPG step: next = (q>>1) ^ (q[0] ? 16'hB400 : 0).
  - SISR step: next = (q>>1) ^ ((q[0]^cut_sdo) ? 16'hB400 : 0).
- IDLE:
  - cut_scanmode=0, cut_sdi=0, bistdone=0, bistpass=0.
  - PRPG reloads PRPG_SEED; SISR clears.
  - bistmode=1 sampled moves to SHIFT.
- SHIFT, CHAIN_LEN cycles per pattern:
  - cut_scanmode=1, cut_sdi=PRPG[0]; PRPG steps each cycle.
  - SISR steps on cut_sdo, except during the first pattern's load (the chain holds no valid response yet).
  - After the last shift cycle, go to CAPTURE.
- CAPTURE, 1 cycle:
  - cut_scanmode=0; PRPG and SISR hold; cut_sdi=PRPG[0].
  - If patterns applied < NUM_PATTERNS, go to SHIFT; else go to UNLOAD.
- UNLOAD, CHAIN_LEN cycles:
  - cut_scanmode=1, cut_sdi=0; PRPG holds; SISR steps on cut_sdo.
  - Then go to DONE.
- DONE:
  - cut_scanmode=0, cut_sdi=0, bistdone=1, bistpass=(SISR==GOLDEN_SIG).
  - Holds while bistmode=1.
- Run length: NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN active cycles; 80 with the defaults.
  - bistdone rises on the (run length + 1)th rising edge after the edge sampling bistmode=1 in IDLE; 81 with the defaults.
- Abort: bistmode=0 sampled in any non-IDLE state moves to IDLE on that edge; outputs return to IDLE values.
- Re-raising bistmode restarts from the seed and produces an identical sequence.
- Counters: chain-bit counter width $clog2(CHAIN_LEN+1); pattern counter width $clog2(NUM_PATTERNS+1). No wrap-around within a run.

Optional Feature:
- Macro: BIST_SIG_OBS_EN.
- Defined: adds output port bist_signature [15:0] = live SISR value, reset 0.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package bist_pkg holds:
  - state enum {IDLE, SHIFT, CAPTURE, UNLOAD, DONE};
  - localparam POLY = 16'hB400;
  - width constant LFSR_W = 16.
- Sub-module bist_lfsr16: Galois LFSR with load, step, and serial-in (si, si_en) inputs.
  - Instantiated twice: PRPG with si_en=0, SISR with si_en=1.
- FSM and counters stay in bist_controller.

Test Plan:
- Reset: reset=1 for 2 cycles with bistmode=0 -> cut_scanmode=0, cut_sdi=0, bistdone=0, bistpass=0.
- Stimulus: defaults, loopback CUT (cut_sdo = cut_sdi delayed by one flop), bistmode=1.
  - First 8 cut_sdi bits: 1,0,0,0,0,1,1,1.
  - cut_scanmode pattern: 8 high, 1 low, repeated.
  - bistdone rises 81 edges after the start sample.
- Pass/fail: GOLDEN_SIG set to the bench-model signature -> bistdone=1, bistpass=1. GOLDEN_SIG = model^16'h0001 -> bistdone=1, bistpass=0.
- Stuck-at-0 CUT: cut_sdo=0 constantly -> final SISR=16'h0000; with GOLDEN_SIG=16'h1234, bistpass=0.
- Abort/restart: bistmode=0 at active cycle 30 -> next edge IDLE, all outputs 0. Re-raise -> cut_sdi sequence restarts at 1,0,0,0,0,1,1,1 and done timing is identical.
- Reset mid-run: reset=1 at active cycle 50 -> IDLE on that edge. Hold bistmode=1 and release reset -> a fresh run starts with the seed.
